// File: rtl/vr_n_to_s_scan_decoder_pkg.sv
// Shared definitions for the N-to-S scan decoder.
//   mode_t      : 2-bit operating mode
//   MODE_*      : mode encodings (static, scan up, scan down, one-shot pulse)
package vr_n_to_s_scan_decoder_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_STATIC = 2'b00;
  localparam mode_t MODE_UP     = 2'b01;
  localparam mode_t MODE_DOWN   = 2'b10;
  localparam mode_t MODE_PULSE  = 2'b11;

endpackage

// File: rtl/vr_n_to_s_scan_decoder_if.sv
// Control/status bundle of the N-to-S scan decoder.
//   en, mode, a, load : driven by the master (controller)
//   y, idx, err, wrap : driven by the slave (decoder)
interface vr_n_to_s_scan_decoder_if
  import vr_n_to_s_scan_decoder_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned S = 8
);

  logic         en;
  mode_t        mode;
  logic [N-1:0] a;
  logic         load;
  logic [S-1:0] y;
  logic [N-1:0] idx;
  logic         err;
  logic         wrap;

  modport master (
    output en, mode, a, load,
    input  y, idx, err, wrap
  );

  modport slave (
    input  en, mode, a, load,
    output y, idx, err, wrap
  );

endinterface

// File: rtl/vr_tick_div.sv
// Scan prescaler: counts 0..DIV-1 while enabled and not cleared, asserting tick
// (combinationally) in the cycle the count sits at DIV-1.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear to 0, suppresses tick
//   en           : count enable
//   tick         : one scan step this cycle
module vr_tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vr_n_to_s_scan_decoder.sv
// Registered N-to-S one-hot decoder with static, scan-up, scan-down and pulse modes.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : en, mode, a, load in; y (one-hot), idx, err, wrap out
module vr_n_to_s_scan_decoder
  import vr_n_to_s_scan_decoder_pkg::*;
#(
  parameter int unsigned N   = 3,
  parameter int unsigned S   = 8,
  parameter int unsigned DIV = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  vr_n_to_s_scan_decoder_if.slave   bus
);

  localparam logic [N-1:0] IdxMax = N'(S - 1);

  logic [S-1:0] y_q, y_d;
  logic [N-1:0] idx_q, idx_d;
  logic         err_q, err_d;
  logic         wrap_q, wrap_d;
  mode_t        mode_q;

  logic a_valid, scan_mode, mode_chg, run, tick;

  function automatic logic [S-1:0] onehot(input logic [N-1:0] k);
    return {{(S-1){1'b0}}, 1'b1} << k;
  endfunction

  assign a_valid   = 32'(bus.a) < S;
  assign scan_mode = (bus.mode == MODE_UP) || (bus.mode == MODE_DOWN);
  assign mode_chg  = bus.mode != mode_q;
  // Prescaler only runs while free-scanning; every other situation restarts it.
  assign run       = bus.en && scan_mode && !bus.load && !err_q && !mode_chg;

  vr_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!run),
    .en      (bus.en),
    .tick    (tick)
  );

  always_comb begin
    y_d    = '0;
    idx_d  = idx_q;
    err_d  = err_q;
    wrap_d = 1'b0;
    if (bus.en) begin
      // Loads (and every static-mode cycle) share the same range-checked decode.
      if (bus.mode == MODE_STATIC || bus.load) begin
        if (a_valid) begin
          idx_d = bus.a;
          y_d   = onehot(bus.a);
          err_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else if (scan_mode && !err_q) begin
        if (tick) begin
          if (bus.mode == MODE_UP) begin
            wrap_d = idx_q == IdxMax;
            idx_d  = wrap_d ? '0 : idx_q + N'(1);
          end else begin
            wrap_d = idx_q == '0;
            idx_d  = wrap_d ? IdxMax : idx_q - N'(1);
          end
        end
        y_d = onehot(idx_d);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q    <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      mode_q <= MODE_STATIC;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
      mode_q <= bus.mode;
    end
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.err  = err_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_vr_n_to_s_scan_decoder.sv
// Bench for vr_n_to_s_scan_decoder: two instances (DIV=2 and DIV=1) share one stimulus
// stream; each is compared every cycle against a behavioural model, plus directed checks.
module tb_vr_n_to_s_scan_decoder;

  localparam int unsigned N = 3;
  localparam int unsigned S = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vr_n_to_s_scan_decoder_if #(.N(N), .S(S)) bus2 ();
  vr_n_to_s_scan_decoder_if #(.N(N), .S(S)) bus1 ();

  vr_n_to_s_scan_decoder #(.N(N), .S(S), .DIV(2)) u_dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  vr_n_to_s_scan_decoder #(.N(N), .S(S), .DIV(1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int idx;
    int y;
    bit err;
    bit wrap;
    int cnt;
    int mprev;
  } mstate_t;

  mstate_t m2, m1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mstate_t mreset();
    mstate_t r;
    r.idx = 0; r.y = 0; r.err = 0; r.wrap = 0; r.cnt = 0; r.mprev = 0;
    return r;
  endfunction

  // One clock of the decoder, straight from the mode rules.
  function automatic mstate_t mstep(input mstate_t s, input int div, input bit en,
                                    input int mode, input int a, input bit load);
    mstate_t n;
    bit chg, tick;
    n = s;
    chg = (mode != s.mprev);
    n.mprev = mode;
    n.wrap = 0;
    n.y = 0;
    if (!en) begin
      n.cnt = 0;
      return n;
    end
    if (mode == 0 || load) begin
      n.cnt = 0;
      if (a < S) begin
        n.idx = a; n.y = 1 << a; n.err = 0;
      end else begin
        n.err = 1;
      end
    end else if (mode == 3 || s.err) begin
      n.cnt = 0;
    end else begin
      tick = !chg && (s.cnt == div - 1);
      n.cnt = (chg || tick) ? 0 : s.cnt + 1;
      if (tick) begin
        if (mode == 1) begin
          n.wrap = (s.idx == S - 1);
          n.idx = (s.idx + 1) % S;
        end else begin
          n.wrap = (s.idx == 0);
          n.idx = (s.idx + S - 1) % S;
        end
      end
      n.y = 1 << n.idx;
    end
    return n;
  endfunction

  task automatic check_all();
    check("d2_y", 32'(bus2.y), m2.y);
    check("d2_idx", 32'(bus2.idx), m2.idx);
    check("d2_err", 32'(bus2.err), 32'(m2.err));
    check("d2_wrap", 32'(bus2.wrap), 32'(m2.wrap));
    check("d1_y", 32'(bus1.y), m1.y);
    check("d1_idx", 32'(bus1.idx), m1.idx);
    check("d1_err", 32'(bus1.err), 32'(m1.err));
    check("d1_wrap", 32'(bus1.wrap), 32'(m1.wrap));
  endtask

  task automatic step(input bit en, input int mode, input int a, input bit load);
    bus2.en = en; bus2.mode = 2'(mode); bus2.a = 3'(a); bus2.load = load;
    bus1.en = en; bus1.mode = 2'(mode); bus1.a = 3'(a); bus1.load = load;
    @(posedge clk);
    m2 = mstep(m2, 2, en, mode, a, load);
    m1 = mstep(m1, 1, en, mode, a, load);
    #1;
    check_all();
  endtask

  initial begin
    int exp_up[6] = '{4, 5, 5, 0, 0, 1};
    bit wrp_up[6] = '{0, 0, 0, 1, 0, 0};
    int exp_dn[3] = '{0, 5, 4};
    bit wrp_dn[3] = '{0, 1, 0};
    int held;
    int rmode;

    bus2.en = 0; bus2.mode = 2'b00; bus2.a = '0; bus2.load = 0;
    bus1.en = 0; bus1.mode = 2'b00; bus1.a = '0; bus1.load = 0;
    m2 = mreset();
    m1 = mreset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", 32'(bus2.y), 0);
    check("rst_idx", 32'(bus2.idx), 0);
    check("rst_err", 32'(bus2.err), 0);
    check("rst_wrap", 32'(bus2.wrap), 0);
    reset_n = 1'b1;

    // Static decode and range error.
    step(1, 0, 4, 0);
    check("st_y", 32'(bus2.y), 32'h10);
    check("st_idx", 32'(bus2.idx), 4);
    step(1, 0, 7, 0);
    check("st_bad_y", 32'(bus2.y), 0);
    check("st_bad_err", 32'(bus2.err), 1);
    check("st_bad_idx", 32'(bus2.idx), 4);

    // Asynchronous reset mid-cycle.
    step(1, 0, 4, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_y", 32'(bus2.y), 0);
    check("async_rst_idx", 32'(bus1.idx), 0);
    m2 = mreset();
    m1 = mreset();
    #1 reset_n = 1'b1;

    // Scan up with wrap (DIV=2 instance).
    step(1, 1, 4, 1);
    check("up_load_y", 32'(bus2.y), 32'h10);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0);
      check("up_idx", 32'(bus2.idx), exp_up[i]);
      check("up_wrap", 32'(bus2.wrap), 32'(wrp_up[i]));
    end

    // Scan down (DIV=1 instance steps every cycle).
    step(1, 2, 1, 1);
    check("dn_load_idx", 32'(bus1.idx), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 2, 0, 0);
      check("dn_idx", 32'(bus1.idx), exp_dn[i]);
      check("dn_wrap", 32'(bus1.wrap), 32'(wrp_dn[i]));
    end

    // Out-of-range load pauses the scan.
    held = m2.idx;
    step(1, 1, 6, 1);
    check("pause_err", 32'(bus2.err), 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0);
      check("pause_y", 32'(bus2.y), 0);
      check("pause_idx", 32'(bus2.idx), held);
    end
    step(1, 1, 2, 1);
    check("resume_err", 32'(bus2.err), 0);
    check("resume_y", 32'(bus2.y), 32'h04);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("resume_step", 32'(bus2.idx), 3);

    // Pulse mode.
    step(1, 3, 3, 1);
    check("pulse_y", 32'(bus2.y), 32'h08);
    step(1, 3, 3, 0);
    check("pulse_end", 32'(bus2.y), 0);
    step(1, 3, 3, 1);
    check("pulse_b2b_a", 32'(bus2.y), 32'h08);
    step(1, 3, 0, 1);
    check("pulse_b2b_b", 32'(bus2.y), 32'h01);
    step(1, 3, 0, 0);
    check("pulse_b2b_end", 32'(bus2.y), 0);

    // Enable drop and re-enable, then mode switch to pulse.
    step(1, 1, 3, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("en_pre_idx", 32'(bus2.idx), 4);
    step(0, 1, 0, 0);
    check("en_off_y", 32'(bus2.y), 0);
    check("en_off_idx", 32'(bus2.idx), 4);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("en_re_y", 32'(bus2.y), 32'h10);
    step(1, 1, 0, 0);
    check("en_re_step", 32'(bus2.idx), 5);
    step(1, 3, 0, 0);
    check("to_pulse_y", 32'(bus2.y), 0);

    // Randomised traffic against the model.
    rmode = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) rmode = $urandom_range(0, 3);
      step($urandom_range(0, 11) != 0, rmode, $urandom_range(0, 7), $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
